// File: rtl/prog_mem_pkg.sv
// Shared definitions for the writable program memory: loader FSM encoding and default fill word.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } pm_state_t;

    localparam logic [7:0] FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read port.
// Addresses at or beyond DEPTH read back as FILL.
module prog_mem_array #(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_comb begin
        rdata = FILL;
        if ({1'b0, raddr} < DEPTH_EXT)
            rdata = mem[raddr];
    end

endmodule

// File: rtl/prog_mem.sv
// Writable program memory with combinational fetch and a handshaked loader.
// Clears to FILL after reset; BUSY holds the CPU off while clearing or loading.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(FILL_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] COMMAND,
    output logic              BUSY,
    input  logic              LD_START,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_DONE,
    output logic              LD_OVF,
    output logic [ADDR_W:0]   LD_COUNT,
    output logic [DATA_W-1:0] CSUM
);

    pm_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              last_ptr;
    logic              xfer;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    assign last_ptr = (ptr == ADDR_W'(DEPTH - 1));
    assign xfer     = (state == ST_LOAD) && LD_VALID;
    assign we       = (state == ST_CLEAR) || xfer;
    assign wdata    = (state == ST_CLEAR) ? FILL : LD_DATA;

    assign BUSY     = (state != ST_RUN);
    assign LD_READY = (state == ST_LOAD);
    // Forcing FILL while busy keeps the fetch port away from in-flight writes.
    assign COMMAND  = BUSY ? FILL : rdata;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (last_ptr) state_nxt = ST_RUN;
            ST_RUN:   if (LD_START) state_nxt = ST_LOAD;
            ST_LOAD:  if (xfer && (LD_LAST || last_ptr)) state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            LD_COUNT <= '0;
            CSUM     <= '0;
            LD_DONE  <= 1'b0;
            LD_OVF   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_CLEAR: ptr <= last_ptr ? '0 : ptr + 1'b1;
                ST_RUN: begin
                    if (LD_START) begin
                        ptr      <= '0;
                        LD_COUNT <= '0;
                        CSUM     <= '0;
                        LD_DONE  <= 1'b0;
                        LD_OVF   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        ptr      <= last_ptr ? '0 : ptr + 1'b1;
                        LD_COUNT <= LD_COUNT + 1'b1;
                        CSUM     <= CSUM + LD_DATA;
                        if (LD_LAST || last_ptr)
                            LD_DONE <= 1'b1;
                        // A full array without LD_LAST means the image was truncated.
                        if (last_ptr && !LD_LAST)
                            LD_OVF <= 1'b1;
                    end
                end
                default: ptr <= '0;
            endcase
        end
    end

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FILL   (FILL)
    ) u_array (
        .clk   (CLK),
        .we    (we),
        .waddr (ptr),
        .wdata (wdata),
        .raddr (ADDR),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: stimulus queues expected values, a negedge monitor compares them.
module tb_prog_mem;

    localparam int S_CMD = 0, S_BUSY = 1, S_RDY = 2, S_DONE = 3, S_OVF = 4, S_CNT = 5, S_CSUM = 6;
    localparam int S_CMD2 = 10, S_BUSY2 = 11, S_RDY2 = 12, S_DONE2 = 13, S_OVF2 = 14, S_CNT2 = 15, S_CSUM2 = 16;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic       CLK = 1'b0;
    logic       RST_N, LD_START, LD_VALID, LD_LAST;
    logic [3:0] ADDR;
    logic [7:0] LD_DATA;
    logic [7:0] COMMAND, CSUM;
    logic       BUSY, LD_READY, LD_DONE, LD_OVF;
    logic [4:0] LD_COUNT;

    logic       rst2_n, ld_start2;
    logic [3:0] addr2;
    logic [7:0] command2, csum2;
    logic       busy2, ld_ready2, ld_done2, ld_ovf2;
    logic [4:0] ld_count2;

    always #5 CLK = ~CLK;

    prog_mem dut (
        .CLK(CLK), .RST_N(RST_N), .ADDR(ADDR), .COMMAND(COMMAND), .BUSY(BUSY),
        .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_DATA(LD_DATA),
        .LD_LAST(LD_LAST), .LD_DONE(LD_DONE), .LD_OVF(LD_OVF), .LD_COUNT(LD_COUNT), .CSUM(CSUM)
    );

    prog_mem #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .FILL(8'hA5)) dut12 (
        .CLK(CLK), .RST_N(rst2_n), .ADDR(addr2), .COMMAND(command2), .BUSY(busy2),
        .LD_START(ld_start2), .LD_VALID(LD_VALID), .LD_READY(ld_ready2), .LD_DATA(LD_DATA),
        .LD_LAST(LD_LAST), .LD_DONE(ld_done2), .LD_OVF(ld_ovf2), .LD_COUNT(ld_count2), .CSUM(csum2)
    );

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_CMD:   return 32'(COMMAND);
            S_BUSY:  return 32'(BUSY);
            S_RDY:   return 32'(LD_READY);
            S_DONE:  return 32'(LD_DONE);
            S_OVF:   return 32'(LD_OVF);
            S_CNT:   return 32'(LD_COUNT);
            S_CSUM:  return 32'(CSUM);
            S_CMD2:  return 32'(command2);
            S_BUSY2: return 32'(busy2);
            S_RDY2:  return 32'(ld_ready2);
            S_DONE2: return 32'(ld_done2);
            S_OVF2:  return 32'(ld_ovf2);
            S_CNT2:  return 32'(ld_count2);
            S_CSUM2: return 32'(csum2);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: everything queued since the last edge is checked at the negedge.
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c   = q.pop_front();
            act = sample(c.sel);
            n_total++;
            if (act === c.exp) n_pass++;
            else $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
        end
    end

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.sel = sel; c.exp = exp;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string name, input int sel, input int max_cyc);
        int n;
        n = 0;
        while (sample(sel) !== 32'd0 && n < max_cyc) begin
            tick();
            n++;
        end
        n_total++;
        if (sample(sel) === 32'd0) n_pass++;
        else $display("FAIL %s: BUSY still high after %0d cycles", name, max_cyc);
    endtask

    task automatic read1(input string name, input logic [3:0] a, input logic [7:0] exp);
        ADDR = a;
        chk(name, S_CMD, 32'(exp));
        tick();
    endtask

    task automatic read2(input string name, input logic [3:0] a, input logic [7:0] exp);
        addr2 = a;
        chk(name, S_CMD2, 32'(exp));
        tick();
    endtask

    task automatic start1();
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
    endtask

    task automatic word(input logic [7:0] d, input logic last);
        LD_VALID = 1'b1; LD_DATA = d; LD_LAST = last;
        tick();
        LD_VALID = 1'b0; LD_LAST = 1'b0;
    endtask

    logic [7:0] img [4];

    initial begin
        img[0] = 8'hB7; img[1] = 8'h01; img[2] = 8'hE1; img[3] = 8'hFF;
        RST_N = 1'b0; LD_START = 1'b0; LD_VALID = 1'b0; LD_LAST = 1'b0;
        ADDR = '0; LD_DATA = '0;
        rst2_n = 1'b0; ld_start2 = 1'b0; addr2 = '0;
        tick();

        // Reset state, then exactly 16 clear cycles.
        n_total++;
        if (BUSY === 1'b1 && LD_READY === 1'b0 && LD_DONE === 1'b0 && LD_OVF === 1'b0 &&
            LD_COUNT === 5'd0 && CSUM === 8'h00)
            n_pass++;
        else
            $display("FAIL rst_direct: BUSY=%b RDY=%b DONE=%b OVF=%b CNT=%0d CSUM=%0h",
                     BUSY, LD_READY, LD_DONE, LD_OVF, LD_COUNT, CSUM);
        chk("rst_busy", S_BUSY, 1); chk("rst_ready", S_RDY, 0); chk("rst_count", S_CNT, 0);
        chk("rst_csum", S_CSUM, 0); chk("rst_done", S_DONE, 0); chk("rst_ovf", S_OVF, 0);
        chk("rst_cmd", S_CMD, 8'h00);
        RST_N = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("clear_busy", S_BUSY, 1);
            tick();
        end
        chk("run_busy", S_BUSY, 0);
        for (int a = 0; a < 16; a++) read1("cleared_cmd", 4'(a), 8'h00);

        // Back-to-back 4-word image.
        start1();
        chk("load_ready", S_RDY, 1); chk("load_busy", S_BUSY, 1); chk("load_cmd_fill", S_CMD, 8'h00);
        for (int i = 0; i < 4; i++) word(img[i], i == 3);
        chk("l4_ready", S_RDY, 0); chk("l4_count", S_CNT, 4); chk("l4_csum", S_CSUM, 8'h98);
        chk("l4_done", S_DONE, 1); chk("l4_ovf", S_OVF, 0); chk("l4_busy", S_BUSY, 0);
        read1("l4_addr2", 4'd2, 8'hE1);
        read1("l4_addr4", 4'd4, 8'h00);
        read1("l4_addr0", 4'd0, 8'hB7);

        // Gapped 3-word image: valid toggles, data held during gaps.
        start1();
        chk("gap_busy", S_BUSY, 1); word(8'h11, 1'b0);
        chk("gap_busy", S_BUSY, 1); tick();
        chk("gap_busy", S_BUSY, 1); word(8'h22, 1'b0);
        chk("gap_busy", S_BUSY, 1); tick();
        chk("gap_busy", S_BUSY, 1); word(8'h33, 1'b1);
        chk("gap_count", S_CNT, 3); chk("gap_csum", S_CSUM, 8'h66); chk("gap_done", S_DONE, 1);
        read1("gap_m0", 4'd0, 8'h11);
        read1("gap_m1", 4'd1, 8'h22);
        read1("gap_m2", 4'd2, 8'h33);
        read1("gap_m3_kept", 4'd3, 8'hFF);

        // 16 words without LD_LAST overflow; a 17th is dropped.
        start1();
        for (int i = 0; i < 16; i++) word(8'(8'h40 + i), 1'b0);
        chk("ovf_flag", S_OVF, 1); chk("ovf_count", S_CNT, 16); chk("ovf_ready", S_RDY, 0);
        chk("ovf_done", S_DONE, 1);
        word(8'hAA, 1'b0);
        chk("ovf_count17", S_CNT, 16); chk("ovf_csum", S_CSUM, 8'h78);
        read1("ovf_m0", 4'd0, 8'h40);
        read1("ovf_m15", 4'd15, 8'h4F);

        // Reset in the middle of a load reruns CLEAR.
        start1();
        word(8'h01, 1'b0);
        word(8'h02, 1'b0);
        RST_N = 1'b0; LD_VALID = 1'b1; LD_DATA = 8'h03;
        tick();
        RST_N = 1'b1; LD_VALID = 1'b0;
        chk("mid_rst_done", S_DONE, 0); chk("mid_rst_count", S_CNT, 0); chk("mid_rst_busy", S_BUSY, 1);
        chk("mid_rst_ovf", S_OVF, 0);
        for (int i = 0; i < 16; i++) tick();
        chk("mid_rst_run", S_BUSY, 0);
        wait_idle("mid_rst_wait", S_BUSY, 4);
        for (int a = 0; a < 16; a++) read1("mid_rst_cmd", 4'(a), 8'h00);

        // DEPTH=12 instance: LD_START ignored during CLEAR, including its last cycle.
        tick();
        rst2_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("d12_clear_busy", S_BUSY2, 1); chk("d12_clear_ready", S_RDY2, 0);
            ld_start2 = (i == 2 || i == 11);
            tick();
        end
        ld_start2 = 1'b0;
        chk("d12_run_busy", S_BUSY2, 0); chk("d12_run_ready", S_RDY2, 0);
        tick();
        chk("d12_no_load", S_BUSY2, 0);
        read2("d12_oor13", 4'd13, 8'hA5);
        ld_start2 = 1'b1;
        tick();
        ld_start2 = 1'b0;
        chk("d12_load_ready", S_RDY2, 1);
        for (int i = 0; i < 12; i++) word(8'h5A, 1'b0);
        wait_idle("d12_wait_idle", S_BUSY2, 4);
        chk("d12_ovf", S_OVF2, 1); chk("d12_count", S_CNT2, 12); chk("d12_csum", S_CSUM2, 8'h38);
        chk("d12_done", S_DONE2, 1);
        read2("d12_m11", 4'd11, 8'h5A);
        read2("d12_m0", 4'd0, 8'h5A);
        read2("d12_oor12", 4'd12, 8'hA5);
        read2("d12_oor13b", 4'd13, 8'hA5);
        chk("d1_untouched", S_BUSY, 0);
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Parametrised, writable successor to the fixed TD4 instruction ROM.
- Holds the CPU program in a DEPTH x DATA_W array with a combinational fetch port, so CPU fetch timing is unchanged.
- Adds a handshaked loader port: after reset the array is cleared to FILL, then a program can be streamed in without rebuilding.
- Sits between the PC and the instruction decoder; BUSY holds the CPU in reset while the array is being cleared or loaded.

Parameters:
- ADDR_W, 4, fetch address width.
- DATA_W, 8, instruction width.
- DEPTH, 16, number of words; DEPTH <= 2**ADDR_W.
- FILL, 8'h00, word written on clear and returned for out-of-range or blocked fetch.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- ADDR  in  ADDR_W  fetch address from PC.
- COMMAND  out  DATA_W  fetched instruction (combinational).
- BUSY  out  1  high while in CLEAR or LOAD; CPU must be held in reset.
- LD_START  in  1  single-cycle request to begin a load.
- LD_VALID  in  1  LD_DATA is valid this cycle.
- LD_READY  out  1  loader accepts a word this cycle.
- LD_DATA  in  DATA_W  program word.
- LD_LAST  in  1  qualifies the final word of the image.
- LD_DONE  out  1  sticky: last load completed.
- LD_OVF  out  1  sticky: image reached DEPTH words without LD_LAST.
- LD_COUNT  out  ADDR_W+1  words accepted in the current or last load.
- CSUM  out  DATA_W  modulo-2**DATA_W sum of accepted words.

Behaviour:
- Reset (RST_N=0 at a CLK edge): state=CLEAR, ptr=0, LD_COUNT=0, CSUM=0, LD_DONE=0, LD_OVF=0, LD_READY=0, BUSY=1.
  - Reset has priority over all other inputs, including in the middle of LOAD; the partial image is discarded and CLEAR reruns.
- CLEAR:
  - Each cycle: mem[ptr]<=FILL, ptr++.
  - The cycle that writes ptr==DEPTH-1 moves to RUN, so CLEAR lasts exactly DEPTH cycles.
  - LD_START is ignored.
- RUN:
  - BUSY=0, LD_READY=0.
  - COMMAND = mem[ADDR] if ADDR < DEPTH, else FILL. No added latency.
  - LD_START=1 -> LOAD next cycle with ptr=0, LD_COUNT=0, CSUM=0, LD_DONE=0, LD_OVF=0.
- LOAD:
  - BUSY=1, LD_READY=1.
  - COMMAND is forced to FILL while BUSY=1, in CLEAR and LOAD alike.
  - Transfer occurs when LD_VALID && LD_READY: mem[ptr]<=LD_DATA, ptr++, LD_COUNT++, CSUM<=CSUM+LD_DATA (carry dropped).
  - Transfer with LD_LAST=1 -> RUN, LD_DONE<=1.
  - Transfer at ptr==DEPTH-1 with LD_LAST=0 -> RUN, LD_DONE<=1, LD_OVF<=1.
  - Transfer at ptr==DEPTH-1 with LD_LAST=1 -> RUN, LD_DONE<=1, LD_OVF stays 0.
  - LD_READY drops in the cycle after the final transfer; further LD_VALID is ignored.
  - LD_VALID=0 stalls indefinitely with no timeout.
  - LD_START is ignored during LOAD.
  - Words above the final ptr keep their previous contents; a short image does not re-clear.
- LD_DONE and LD_OVF stay set until the next accepted LD_START or reset.
- Simultaneous events:
  - LD_START in the same cycle as the last CLEAR write is ignored; the requester must reissue it in RUN.
  - In LOAD the mem write and the COMMAND read never collide, because COMMAND is forced to FILL.

Decomposition:
- Package prog_mem_pkg holds the state encoding (CLEAR, RUN, LOAD as a 2-bit enum) and the default FILL constant.
- Sub-module prog_mem_array: DEPTH x DATA_W storage, one synchronous write port (we, waddr, wdata), one combinational read port with out-of-range -> FILL.
- Top level: FSM, pointer, counters, checksum, output muxing.

Test Plan:
- Reset, then hold RST_N=1 -> BUSY=1 for exactly 16 cycles, then BUSY=0; COMMAND=8'h00 for ADDR 0..15.
- LD_START, then 4 words 8'hB7,8'h01,8'hE1,8'hFF back-to-back, LD_LAST on the 4th -> LD_COUNT=4, CSUM=8'h98, LD_DONE=1, LD_OVF=0; ADDR=2 reads 8'hE1, ADDR=4 reads 8'h00.
- LD_VALID toggled 1/0 every other cycle over a 3-word load -> exactly 3 writes, no duplicate writes, BUSY high throughout LOAD.
- 16 words with no LD_LAST -> LD_OVF=1, LD_COUNT=16, LD_READY=0 in the following cycle; a 17th word is dropped and mem[0] is unchanged.
- RST_N=0 pulse after 2 of 5 load words -> CLEAR reruns; all addresses read 8'h00; LD_DONE=0, LD_COUNT=0.
- DEPTH=12, ADDR_W=4: ADDR=13 -> COMMAND=FILL. LD_START pulsed during CLEAR -> stays CLEAR, no LOAD is entered.
